barrett_arbiter: RTL and testbench
==================================

Name: barrett_arbiter

Overview:
- Shares one pipelined Barrett reducer (c mod q, q = 3329) among NUM_REQ requesters, e.g. butterfly lanes of the NTT core.
- Arbitrates round-robin, then tags each accepted operand with its requester ID.
- Runs a fixed-latency 3-stage reduction pipeline.
- Returns results on a single tagged response bus with backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), tag width
- Q, 16'd3329, modulus
- MU, 32'h13AFB7, floor(2^32 / Q)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_data  in  NUM_REQ*32  operands; requester i at bits [32*i+31 : 32*i]
- req_ready  out  NUM_REQ  one-hot grant/accept
- rsp_valid  out  1  result valid
- rsp_id  out  ID_W  requester that issued the result
- rsp_data  out  16  c mod Q, always < Q
- rsp_ready  in  1  consumer accepts result
- busy  out  1  any pipeline stage holds a valid entry

Behaviour:
- Reset values: all registered state clears; rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0, busy=0.
- Round-robin pointer resets to 0. Reset mid-operation discards all in-flight entries; nothing is returned for them.
- Pipeline advance:
  - advance = !(rsp_valid && !rsp_ready).
  - All stages move together (single global stall). No bubble collapsing.
- Arbitration (combinational, same cycle):
  - If advance, grant the first requester with req_valid=1, searching from rr_ptr upward with wrap-around.
  - req_ready is one-hot on the winner and 0 elsewhere; it is all-zero when stalled or when no request is pending.
  - A transfer occurs when req_valid[i] && req_ready[i].
  - On a transfer, rr_ptr <= (winner+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Stage S1 (registered on transfer): v1, id1, c1 = selected operand. When advance holds with no transfer, v1 <= 0.
- Stage S2: v2, id2, c2 <= c1, qhat <= (c1*MU)[63:32]. The 64-bit product is kept in full width.
- Stage S3: v3=rsp_valid, id3=rsp_id, rsp_data.
  - r = c2 - qhat*Q, computed in 32 bits; exact because r < 3Q.
  - Subtract Q conditionally up to twice, so rsp_data < Q always.
- Latency: transfer in cycle T gives rsp_valid in cycle T+3 when unstalled. Each stall cycle adds one.
- Throughput: one result per cycle when rsp_ready=1.
- Stall: while rsp_valid && !rsp_ready, rsp_valid, rsp_id and rsp_data hold stable. No grants are issued. Requesters must keep req_valid/req_data stable until accepted.
- Simultaneous events: when a new request and a drain of S3 happen in the same cycle, both proceed. Requester order of results equals acceptance order.
- busy = v1 | v2 | v3.
- Unused data bits (ID_W rounding when NUM_REQ is not a power of two) never appear; rsp_id < NUM_REQ always.

Optional Feature:
- Macro BARRETT_ARB_STATS_EN.
- With the macro defined, extra output port grant_cnt (NUM_REQ*16) is present: per-requester saturating 16-bit accept counters.
  - Counters clear on rst, increment on each transfer of that requester, and saturate at 16'hFFFF.
- Without the macro, the port and counters do not exist and all other behaviour is identical.

Decomposition:
- Shared package ntt_pkg holds:
  - localparams Q_KYBER=3329 and MU_KYBER=32'h13AFB7
  - typedef coeff_t (logic [15:0])
  - typedef wide_t (logic [31:0])
- Sub-module barrett_pipe: S1..S3 with in_valid/in_id/in_c, advance, and out_* ports. The arbiter top holds rr_ptr, grant logic, stall generation and the optional stats.

Test Plan:
- Single requester 0 sends 3329, 3330, 12345, 0xFFFFFFFF back-to-back with rsp_ready=1 -> rsp_data 0, 1, 2358, 1352, arriving in cycles T+3..T+6, all with rsp_id=0.
- All 4 requesters hold req_valid=1 continuously from reset -> grants 0,1,2,3,0,1,...; rsp_id sequence matches; one result per cycle.
- Requesters 1 and 3 only, rr_ptr=2 -> grant 3 first, then 1, then 3.
- Hold rsp_ready=0 for 5 cycles with 3 entries in flight -> req_ready all 0; rsp_valid/id/data stable. On release, the 3 results drain in order with no loss or duplication.
- Assert rst for 1 cycle with 3 entries in flight -> next cycle rsp_valid=0 and busy=0; rr_ptr=0; no stale result appears afterwards.
- Random 10k operands from random requesters with random rsp_ready -> every rsp_data equals c % 3329 and per-requester order is preserved. With BARRETT_ARB_STATS_EN, grant_cnt totals equal the accepted counts.

Source files
------------

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared Kyber modulus constants and coefficient types for the NTT datapath.
package ntt_pkg;
    localparam logic [15:0] Q_KYBER  = 16'd3329;
    localparam logic [31:0] MU_KYBER = 32'h13AFB7;
    typedef logic [15:0] coeff_t;
    typedef logic [31:0] wide_t;
endpackage

// File: rtl/barrett_pipe.sv
// barrett_pipe: 3-stage Barrett reduction c mod Q with id tag and a single global advance.
module barrett_pipe
    import ntt_pkg::*;
#(
    parameter int          ID_W = 2,
    parameter logic [15:0] Q    = Q_KYBER,
    parameter logic [31:0] MU   = MU_KYBER
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    input  logic [31:0]     in_c,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic [15:0]     out_data,
    output logic            busy
);
    logic            v1, v2;
    logic [ID_W-1:0] id1, id2;
    wide_t           c1, c2, qhat, qhat_n, r0, r1, r2;

    // qhat never exceeds floor(c/Q), so r0 lies in [0, 3Q)
    assign qhat_n = wide_t'(({32'd0, c1} * {32'd0, MU}) >> 32);
    assign r0     = c2 - qhat * {16'd0, Q};
    assign r1     = (r0 >= {16'd0, Q}) ? r0 - {16'd0, Q} : r0;
    assign r2     = (r1 >= {16'd0, Q}) ? r1 - {16'd0, Q} : r1;
    assign busy   = v1 | v2 | out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            id1       <= '0;
            id2       <= '0;
            out_id    <= '0;
            c1        <= '0;
            c2        <= '0;
            qhat      <= '0;
            out_data  <= '0;
        end else if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            if (in_valid) begin
                id1 <= in_id;
                c1  <= in_c;
            end
            if (v1) begin
                id2  <= id1;
                c2   <= c1;
                qhat <= qhat_n;
            end
            if (v2) begin
                out_id   <= id2;
                out_data <= coeff_t'(r2);
            end
        end
    end
endmodule

// File: rtl/barrett_arbiter.sv
// barrett_arbiter: round-robin share of one Barrett reducer among NUM_REQ requesters.
// Define BARRETT_ARB_STATS_EN to add saturating per-requester accept counters on grant_cnt.
module barrett_arbiter
    import ntt_pkg::*;
#(
    parameter int          NUM_REQ = 4,
    parameter int          ID_W    = $clog2(NUM_REQ),
    parameter logic [15:0] Q       = Q_KYBER,
    parameter logic [31:0] MU      = MU_KYBER
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_data,
    input  logic                 rsp_ready,
    output logic                 busy
`ifdef BARRETT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);
    logic            advance, found, transfer;
    logic [ID_W-1:0] rr_ptr, winner, idx;
    wide_t           sel;

    assign advance = !(rsp_valid && !rsp_ready);

    // descending scan so the requester closest to rr_ptr is written last and wins
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign transfer  = advance && found && !rst;
    assign req_ready = transfer ? NUM_REQ'(1) << winner : '0;
    assign sel       = req_data[{winner, 5'd0} +: 32];

    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= '0;
        else if (transfer) rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    barrett_pipe #(.ID_W(ID_W), .Q(Q), .MU(MU)) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .in_valid (transfer),
        .in_id    (winner),
        .in_c     (sel),
        .out_valid(rsp_valid),
        .out_id   (rsp_id),
        .out_data (rsp_data),
        .busy     (busy)
    );

`ifdef BARRETT_ARB_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) cnt[i] <= '0;
            else if (req_ready[i] && req_valid[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_cnt[16*i +: 16] = cnt[i];
    end
`endif
endmodule

// File: tb/tb_barrett_arbiter.sv
// tb_barrett_arbiter: scoreboard bench; model does round-robin selection and c % 3329.
module tb_barrett_arbiter;
    localparam int N  = 4;
    localparam int QM = 3329;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*32-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [15:0]   rsp_data;
    logic          rsp_ready = 1'b1;
    logic          busy;
`ifdef BARRETT_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    barrett_arbiter #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .rsp_ready(rsp_ready),
        .busy     (busy)
`ifdef BARRETT_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int     id;
        int     res;
        longint acc_cyc;
        longint stall_base;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] feed [N][$];
    int          checks = 0, errors = 0;
    longint      cyc = 0, stall_cnt = 0;
    int          rr_m = 0, total = 0, w = -1;
    int          acc_cnt [N];
    bit          head_seen = 0, post_rst = 0, adv = 0, rand_mode = 0, rdy_force = 1;
    logic [N-1:0] acc_mask = '0, exp_rdy = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(9))
            0: return 32'd0;
            1: return 32'd3328;
            2: return 32'd3329;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // monitor: models grants, pushes expected results, checks responses
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("ready_in_rst", {60'd0, req_ready}, 64'd0);
            sb.delete();
            rr_m = 0;
            head_seen = 0;
            post_rst = 1;
            acc_mask = '0;
            for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        end else begin
            if (post_rst) begin
                chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
                chk("rst_rsp_data", {48'd0, rsp_data}, 64'd0);
                post_rst = 0;
            end
            adv = !(rsp_valid && !rsp_ready);
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && req_valid[(rr_m + k) % N]) w = (rr_m + k) % N;
            exp_rdy = (adv && w >= 0) ? N'(1 << w) : '0;
            chk("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
            acc_mask = req_valid & req_ready;
            if (exp_rdy != 0) begin
                sb.push_back('{w, int'(req_data[32*w +: 32] % QM), cyc, stall_cnt});
                rr_m = (w + 1) % N;
                acc_cnt[w]++;
                total++;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual id=%0d data=%0d required no response cycle=%0d", rsp_id, rsp_data, cyc);
                end else begin
                    chk("rsp_id", {62'd0, rsp_id}, 64'(sb[0].id));
                    chk("rsp_data", {48'd0, rsp_data}, 64'(sb[0].res));
                    if (!head_seen)
                        chk("latency", 64'(cyc), 64'(sb[0].acc_cyc + 3 + (stall_cnt - sb[0].stall_base)));
                    head_seen = 1;
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        head_seen = 0;
                    end
                end
            end
            if (rsp_valid && !rsp_ready) stall_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i] || rst) req_valid[i] = 1'b0;
            if (!req_valid[i] && !rst) begin
                if (feed[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_data[32*i +: 32] = feed[i].pop_front();
                end else if (rand_mode && $urandom_range(1) == 1) begin
                    req_valid[i] = 1'b1;
                    req_data[32*i +: 32] = rand_op();
                end
            end
        end
        rsp_ready = rand_mode ? ($urandom_range(9) < 7) : rdy_force;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) feed[i].delete();
        step();
        rst = 1'b0;
    endtask

    initial begin
        cycles(2);
        rst = 1'b0;
        cycles(2);
        // known operands on requester 0
        feed[0].push_back(32'd3329);
        feed[0].push_back(32'd3330);
        feed[0].push_back(32'd12345);
        feed[0].push_back(32'hFFFF_FFFF);
        cycles(10);
        // all requesters continuously valid from reset
        do_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 8; j++) feed[i].push_back($urandom);
        cycles(45);
        // requesters 1 and 3 with rr_ptr at 2
        do_reset();
        feed[1].push_back($urandom);
        cycles(6);
        feed[1].push_back($urandom);
        feed[1].push_back($urandom);
        feed[3].push_back($urandom);
        feed[3].push_back($urandom);
        cycles(10);
        // backpressure with three entries in flight
        rdy_force = 0;
        for (int j = 0; j < 3; j++) feed[2].push_back($urandom);
        cycles(4);
        feed[0].push_back($urandom);
        cycles(6);
        rdy_force = 1;
        cycles(10);
        // reset with entries in flight
        rdy_force = 0;
        for (int j = 0; j < 3; j++) feed[1].push_back($urandom);
        cycles(5);
        do_reset();
        rdy_force = 1;
        cycles(10);
        // random traffic
        do_reset();
        rand_mode = 1;
        while (total < 10000 && cyc < 60000) step();
        chk("random_accepts", 64'(total >= 10000), 64'd1);
        rand_mode = 0;
        rdy_force = 1;
        for (int n = 0; n < 100 && (sb.size() > 0 || req_valid != 0); n++) step();
        cycles(2);
        #2;
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
`ifdef BARRETT_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_cnt", {48'd0, grant_cnt[16*i +: 16]}, 64'(acc_cnt[i]));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
